mem_bus_arbiter: RTL and testbench

Two-master arbiter and access sequencer in front of the memory map decoder. It shares the single decoder port (MemRead/MemWrite/address/write data/read data) between the CPU data port (master 0) and a secondary master such as a UART boot loader or debug port (master 1), using round-robin fairness. Each access is stretched to a fixed wait-state count, and addresses outside the implemented map are rejected with an error response instead of being driven to the decoder.

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: memory map window, FSM encoding,
// master indices and the mapped-address test.
package mem_bus_arbiter_pkg;

    // Implemented memory map window, inclusive on both ends
    localparam logic [31:0] MAP_LOW  = 32'h0040_0000;
    localparam logic [31:0] MAP_HIGH = 32'h7FFF_FFFF;

    // Access sequencer state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Master indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Wait-state down-counter width
    localparam int unsigned CNT_W = 4;

    // True when the address falls inside the implemented map
    function automatic logic addr_mapped(input logic [63:0] addr);
        return (addr >= 64'(MAP_LOW)) && (addr <= 64'(MAP_HIGH));
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_c_o,
    output logic       winner_c_o
);

    // Combinational winner selection
    always_comb begin
        valid_c_o  = |req_i;
        winner_c_o = M0;
        case (req_i)
            2'b01:   winner_c_o = M0;
            2'b10:   winner_c_o = M1;
            2'b11:   winner_c_o = ~last_grant_i;
            default: winner_c_o = M0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and access sequencer in front of the memory map decoder.
// Each transfer runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP; unmapped
// addresses never strobe the decoder and complete with err.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] AddrBus,
    output logic [DATA_WIDTH-1:0] WDataBus,
    input  logic [DATA_WIDTH-1:0] RDataBus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic             WAIT0    = (WAIT_CYCLES == 0);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic                  mapped_q, mapped_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    logic                  pick_valid;
    logic                  pick;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_mapped;

    rr_pick2 u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .valid_c_o    (pick_valid),
        .winner_c_o   (pick)
    );

    // Steer the winning master's request fields
    always_comb begin
        win_we     = (pick == M1) ? m1_we    : m0_we;
        win_addr   = (pick == M1) ? m1_addr  : m0_addr;
        win_wdata  = (pick == M1) ? m1_wdata : m0_wdata;
        win_mapped = addr_mapped(64'(win_addr));
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mapped_d     = mapped_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        gnt_d        = 2'b00;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        rdata_d[0]   = '0;
        rdata_d[1]   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_ACCESS;
                    cnt_d        = CNT_LOAD;
                    owner_d      = pick;
                    last_grant_d = pick;
                    we_d         = win_we;
                    mapped_d     = win_mapped;
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    gnt_d[pick]  = 1'b1;
                    mem_read_d   = win_mapped && !win_we;
                    // With no wait states the first ACCESS cycle is also the last
                    mem_write_d  = win_mapped && win_we && WAIT0;
                end
            end
            ST_ACCESS: begin
                gnt_d[owner_q] = 1'b1;
                if (cnt_q == '0) begin
                    state_d          = ST_RESP;
                    ack_d[owner_q]   = 1'b1;
                    err_d[owner_q]   = !mapped_q;
                    rdata_d[owner_q] = (mapped_q && !we_q) ? RDataBus : '0;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_read_d  = mapped_q && !we_q;
                    mem_write_d = mapped_q && we_q && (cnt_q == CNT_W'(1));
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= M0;
            last_grant_q <= M1;
            we_q         <= 1'b0;
            mapped_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mapped_q     <= mapped_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign m0_gnt   = gnt_q[0];
    assign m1_gnt   = gnt_q[1];
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign AddrBus  = addr_q;
    assign WDataBus = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transfers on a
// WAIT_CYCLES=1 build, plus round-robin, reset-abort and zero-wait sequences.
module tb_mem_bus_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] AddrBus, WDataBus, RDataBus;

    // Zero-wait-state instance signals
    logic        z_req, z_we;
    logic [31:0] z_addr, z_wdata, z_rdbus;
    logic        z_gnt, z_ack, z_err, z1_gnt, z1_ack, z1_err;
    logic [31:0] z_rdata, z1_rdata, z_abus, z_wbus;
    logic        z_rd, z_wr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .AddrBus(AddrBus),
        .WDataBus(WDataBus), .RDataBus(RDataBus)
    );

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .m0_req(z_req), .m0_we(z_we), .m0_addr(z_addr), .m0_wdata(z_wdata),
        .m0_gnt(z_gnt), .m0_ack(z_ack), .m0_err(z_err), .m0_rdata(z_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_gnt(z1_gnt), .m1_ack(z1_ack), .m1_err(z1_err), .m1_rdata(z1_rdata),
        .MemRead(z_rd), .MemWrite(z_wr), .AddrBus(z_abus),
        .WDataBus(z_wbus), .RDataBus(z_rdbus)
    );

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdbus;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_master(input logic m, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transfer from a single master, observed every cycle on the falling edge
    task automatic run_txn(input int idx, input vec_t v);
        int          rd_cnt = 0;
        int          wr_cnt = 0;
        int          ack_k  = 0;
        logic        other_bad = 1'b0;
        logic        gnt1 = 1'b0;
        logic [31:0] addr1 = '0;
        logic [31:0] got_wdata = '0;
        logic        got_err = 1'b0;
        logic [31:0] got_rdata = '0;
        @(negedge clk);
        RDataBus = v.rdbus;
        set_master(v.m, 1'b1, v.we, v.addr, v.wdata);
        @(posedge clk);
        for (int k = 1; k <= 12 && ack_k == 0; k++) begin
            @(negedge clk);
            if (MemRead) rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                got_wdata = WDataBus;
            end
            if (k == 1) begin
                gnt1  = v.m ? m1_gnt : m0_gnt;
                addr1 = AddrBus;
            end
            if (v.m ? (m0_gnt || m0_ack || m0_err || m0_rdata != 0)
                    : (m1_gnt || m1_ack || m1_err || m1_rdata != 0))
                other_bad = 1'b1;
            if (v.m ? m1_ack : m0_ack) begin
                ack_k     = k;
                got_err   = v.m ? m1_err : m0_err;
                got_rdata = v.m ? m1_rdata : m0_rdata;
                set_master(v.m, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        if (ack_k == 0) set_master(v.m, 1'b0, v.we, v.addr, v.wdata);
        chk($sformatf("v%0d ack_cycle", idx), 64'(ack_k), 64'(W + 2));
        chk($sformatf("v%0d memread_cycles", idx), 64'(rd_cnt), 64'(v.exp_rd));
        chk($sformatf("v%0d memwrite_cycles", idx), 64'(wr_cnt), 64'(v.exp_wr));
        chk($sformatf("v%0d err", idx), 64'(got_err), 64'(v.exp_err));
        chk($sformatf("v%0d rdata", idx), 64'(got_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d gnt_first", idx), 64'(gnt1), 64'(1));
        chk($sformatf("v%0d addrbus", idx), 64'(addr1), 64'(v.addr));
        chk($sformatf("v%0d other_quiet", idx), 64'(other_bad), 64'(0));
        if (v.exp_wr != 0)
            chk($sformatf("v%0d wdatabus", idx), 64'(got_wdata), 64'(v.wdata));
        @(negedge clk);
        chk($sformatf("v%0d ack_one_cycle", idx), 64'(v.m ? m1_ack : m0_ack), 64'(0));
    endtask

    initial begin
        int order [4];
        int n_ack;
        int ack_k;
        int rd_cnt;
        int wr_cnt;
        logic        bad;
        logic [31:0] got_rdata;
        int exp_order [4] = '{0, 1, 0, 1};

        vecs[0] = '{1'b0, 1'b0, 32'h1001_0000, 32'h0,         32'hDEB1_0000, 1'b0, 32'hDEB1_0000, 2, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h1001_002C, 32'hF1FA_000A, 32'h1111_2222, 1'b0, 32'h0,         0, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h003F_FFFF, 32'h0,         32'h1234_5678, 1'b1, 32'h0,         0, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h8765_4321, 1'b1, 32'h0,         0, 0};
        vecs[4] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 2, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0,         32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 2, 0};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'hCAFE_0001, 32'h0,         1'b1, 32'h0,         0, 0};
        vecs[7] = '{1'b1, 1'b1, 32'h0040_0000, 32'h0000_0001, 32'h0,         1'b0, 32'h0,         0, 1};

        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        RDataBus = 0;
        z_req = 0; z_we = 0; z_addr = 0; z_wdata = 0; z_rdbus = 0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
        chk("reset ack_err", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        chk("reset rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
        chk("reset strobes", 64'({MemRead, MemWrite}), 64'(0));
        chk("reset buses", 64'({AddrBus, WDataBus}), 64'(0));
        rst = 1'b0;

        foreach (vecs[i]) run_txn(i, vecs[i]);

        // Both masters requesting continuously: alternation starts with m0
        reset_dut();
        RDataBus = 32'h0000_1234;
        set_master(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        set_master(1'b1, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) chk("rr exclusive_gnt", 64'(1), 64'(0));
            if (m0_ack) begin order[n_ack] = 0; n_ack++; end
            else if (m1_ack) begin order[n_ack] = 1; n_ack++; end
        end
        m0_req = 0; m1_req = 0;
        chk("rr ack_count", 64'(n_ack), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < n_ack) chk($sformatf("rr order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        @(negedge clk);

        // Reset in the first ACCESS cycle of an m0 write aborts it cleanly
        reset_dut();
        set_master(1'b0, 1'b1, 1'b1, 32'h1001_002C, 32'h0000_0055);
        @(posedge clk);
        @(negedge clk);
        chk("abort gnt_before", 64'(m0_gnt), 64'(1));
        rst = 1'b1;
        m0_req = 0;
        @(negedge clk);
        chk("abort gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
        chk("abort ack_err", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        chk("abort strobes", 64'({MemRead, MemWrite}), 64'(0));
        chk("abort buses", 64'({AddrBus, WDataBus}), 64'(0));
        rst = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (MemWrite || MemRead || m0_ack || m0_gnt) bad = 1'b1;
        end
        chk("abort no_late_activity", 64'(bad), 64'(0));
        run_txn(100, '{1'b1, 1'b0, 32'h1001_0010, 32'h0, 32'h5EED_0002, 1'b0, 32'h5EED_0002, 2, 0});

        // Zero-wait-state build: read then write, ack two edges after sampling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            z_we = (i == 1); z_addr = 32'h0040_0010; z_wdata = 32'h0000_00AB;
            z_rdbus = 32'h0000_BEEF; z_req = 1'b1;
            @(posedge clk);
            ack_k = 0; rd_cnt = 0; wr_cnt = 0; got_rdata = '0;
            for (int k = 1; k <= 8 && ack_k == 0; k++) begin
                @(negedge clk);
                if (z_rd) rd_cnt++;
                if (z_wr) wr_cnt++;
                if (z_ack) begin ack_k = k; got_rdata = z_rdata; z_req = 1'b0; end
            end
            z_req = 1'b0;
            chk($sformatf("w0_%0d ack_cycle", i), 64'(ack_k), 64'(2));
            chk($sformatf("w0_%0d memread_cycles", i), 64'(rd_cnt), 64'(i == 0 ? 1 : 0));
            chk($sformatf("w0_%0d memwrite_cycles", i), 64'(wr_cnt), 64'(i == 1 ? 1 : 0));
            chk($sformatf("w0_%0d rdata", i), 64'(got_rdata), 64'(i == 0 ? 32'h0000_BEEF : 32'h0));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
